mul_rs: RTL and testbench

Multiply reservation station with its own iterative multiply unit for the Tomasulo core. It accepts decoded multiply instructions in parallel with addRS, loadRS, storeRS and bneRS, using the same regfile and regstatus operand and tag buses. It snoops both CDBs (add and load) for pending operands, issues one ready entry at a time to a multi-cycle multiplier, and drives a third CDB source with a valid/grant handshake. Its results reach the reorder buffer and every other reservation station.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_unit.sv | 131 +++++++++++++
 rtl/mul_rs.sv | 196 +++++++++++++++++++
 tb/tb_mul_rs.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the multiply reservation station.
//   DATA_W        operand / result width
//   ROB_W_DEFAULT default reorder-buffer index width
//   SUB_MUL/MULH  operatorSubType encodings accepted on issueSub
//   mul_state_e   iterative multiplier FSM states
package mul_pkg;

   localparam int DATA_W        = 32;
   localparam int ROB_W_DEFAULT = 3;

   localparam logic [3:0] SUB_MUL  = 4'd0;
   localparam logic [3:0] SUB_MULH = 4'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier with a CDB request/grant output stage.
//   clock, reset (sync, active-low), flush (active-high)
//   start, op_a, op_b, op_rob   dispatch from the station (accepted only when idle)
//   op_hi                       select high word (only with MUL_HIGH_EN)
//   cdbGrant                    CDB accepted the pending result
//   idle                        unit can take a dispatch this cycle
//   cdbValid, cdbRob, cdbData   registered CDB request
// Optional feature: MUL_HIGH_EN widens the accumulator to 64 bits and enables
// high-word results; without it the accumulator is 32 bits and op_hi does not exist.
//
// state | meaning
// IDLE  | waiting for a dispatch
// BUSY  | accumulating DATA_W/LATENCY multiplier bits per cycle
// DONE  | result held on the CDB until granted
module mul_unit
   import mul_pkg::*;
#(
   parameter int ROB_W   = ROB_W_DEFAULT,
   parameter int LATENCY = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
`ifdef MUL_HIGH_EN
   input  logic              op_hi,
`endif
   input  logic [ROB_W-1:0]  op_rob,
   input  logic              cdbGrant,
   output logic              idle,
   output logic              cdbValid,
   output logic [ROB_W-1:0]  cdbRob,
   output logic [DATA_W-1:0] cdbData
);

   localparam int STEP  = DATA_W / LATENCY;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef MUL_HIGH_EN
   localparam int ACC_W = 2 * DATA_W;
`else
   localparam int ACC_W = DATA_W;
`endif

   mul_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [ACC_W-1:0]  a_sh;
   logic [DATA_W-1:0] b_sh;
   logic [ROB_W-1:0]  rob_q;
   logic [DATA_W-1:0] result;
`ifdef MUL_HIGH_EN
   logic              hi_q;
`endif

   assign idle = (state == IDLE);

   // One slice of the multiplier per cycle; a_sh already carries the slice weight.
   always_comb begin
      acc_next = acc;
      for (int j = 0; j < STEP; j++) begin
         if (b_sh[j]) acc_next = acc_next + (a_sh << j);
      end
   end

   // Result is taken from acc_next so the last slice lands on the same edge as DONE.
`ifdef MUL_HIGH_EN
   assign result = hi_q ? acc_next[ACC_W-1:DATA_W] : acc_next[DATA_W-1:0];
`else
   assign result = acc_next[DATA_W-1:0];
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         rob_q    <= '0;
`ifdef MUL_HIGH_EN
         hi_q     <= 1'b0;
`endif
         cdbValid <= 1'b0;
         cdbRob   <= '0;
         cdbData  <= '0;
      end else if (flush) begin
         state    <= IDLE;
         cdbValid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= BUSY;
                  cnt   <= CNT_W'(LATENCY - 1);
                  acc   <= '0;
                  a_sh  <= ACC_W'(op_a);
                  b_sh  <= op_b;
                  rob_q <= op_rob;
`ifdef MUL_HIGH_EN
                  hi_q  <= op_hi;
`endif
               end
            end
            BUSY: begin
               acc  <= acc_next;
               a_sh <= a_sh << STEP;
               b_sh <= b_sh >> STEP;
               if (cnt == '0) begin
                  state    <= DONE;
                  cdbValid <= 1'b1;
                  cdbRob   <= rob_q;
                  cdbData  <= result;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (cdbGrant) begin
                  state    <= IDLE;
                  cdbValid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mul_rs.sv
// mul_rs: multiply reservation station for the Tomasulo core.
//   clock, reset (sync, active-low), flush (active-high, ROB resetAll)
//   issueValid/issueSub/robNum/data1/data2/q1Valid/q2Valid/q1/q2   issue bus
//   cdb1* (add CDB), cdb2* (load CDB)                              snooped results
//   available                                                      a slot is free
//   cdbValid/cdbRob/cdbData/cdbGrant                               result CDB handshake
// Optional feature: MUL_HIGH_EN enables mulh (issueSub=1 returns the high word).
// Without it issueSub is ignored and every multiply returns the low word.
module mul_rs
   import mul_pkg::*;
#(
   parameter int ENTRIES = 2,
   parameter int ROB_W   = ROB_W_DEFAULT,
   parameter int LATENCY = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              issueValid,
   input  logic [3:0]        issueSub,
   input  logic [ROB_W-1:0]  robNum,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic              q1Valid,
   input  logic              q2Valid,
   input  logic [ROB_W-1:0]  q1,
   input  logic [ROB_W-1:0]  q2,
   input  logic              cdb1Valid,
   input  logic [ROB_W-1:0]  cdb1Rob,
   input  logic [DATA_W-1:0] cdb1Data,
   input  logic              cdb2Valid,
   input  logic [ROB_W-1:0]  cdb2Rob,
   input  logic [DATA_W-1:0] cdb2Data,
   output logic              available,
   output logic              cdbValid,
   output logic [ROB_W-1:0]  cdbRob,
   output logic [DATA_W-1:0] cdbData,
   input  logic              cdbGrant
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] busy;
   logic [ENTRIES-1:0] p1;
   logic [ENTRIES-1:0] p2;
   logic [ROB_W-1:0]   dest    [ENTRIES];
   logic [ROB_W-1:0]   slot_q1 [ENTRIES];
   logic [ROB_W-1:0]   slot_q2 [ENTRIES];
   logic [DATA_W-1:0]  slot_v1 [ENTRIES];
   logic [DATA_W-1:0]  slot_v2 [ENTRIES];
`ifdef MUL_HIGH_EN
   logic [ENTRIES-1:0] slot_hi;
`else
   logic               unused_sub;
   assign unused_sub = ^issueSub;
`endif

   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               rdy_found;
   logic [IDX_W-1:0]   rdy_idx;
   logic               do_issue;
   logic               dispatch;
   logic               unit_idle;

   // {DATA_W+1} = {still_pending, value}
   logic [DATA_W:0]    iss_r1;
   logic [DATA_W:0]    iss_r2;
   logic [DATA_W:0]    snp_r1 [ENTRIES];
   logic [DATA_W:0]    snp_r2 [ENTRIES];

   // Resolve one operand against both CDBs; cdb1 is checked first so it wins a tie.
   function automatic logic [DATA_W:0] resolve(
      input logic              pend,
      input logic [ROB_W-1:0]  tag,
      input logic [DATA_W-1:0] val,
      input logic              c1_v,
      input logic [ROB_W-1:0]  c1_r,
      input logic [DATA_W-1:0] c1_d,
      input logic              c2_v,
      input logic [ROB_W-1:0]  c2_r,
      input logic [DATA_W-1:0] c2_d
   );
      logic [DATA_W:0] r;
      r = {pend, val};
      if (pend) begin
         if (c1_v && (c1_r == tag))      r = {1'b0, c1_d};
         else if (c2_v && (c2_r == tag)) r = {1'b0, c2_d};
      end
      return r;
   endfunction

   always_comb begin
      iss_r1 = resolve(q1Valid, q1, data1, cdb1Valid, cdb1Rob, cdb1Data,
                       cdb2Valid, cdb2Rob, cdb2Data);
      iss_r2 = resolve(q2Valid, q2, data2, cdb1Valid, cdb1Rob, cdb1Data,
                       cdb2Valid, cdb2Rob, cdb2Data);
      for (int i = 0; i < ENTRIES; i++) begin
         snp_r1[i] = resolve(p1[i], slot_q1[i], slot_v1[i], cdb1Valid, cdb1Rob, cdb1Data,
                             cdb2Valid, cdb2Rob, cdb2Data);
         snp_r2[i] = resolve(p2[i], slot_q2[i], slot_v2[i], cdb1Valid, cdb1Rob, cdb1Data,
                             cdb2Valid, cdb2Rob, cdb2Data);
      end
   end

   // Priority pickers scan high-to-low so the lowest index is left standing.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      rdy_found  = 1'b0;
      rdy_idx    = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (busy[i] && !p1[i] && !p2[i]) begin
            rdy_found = 1'b1;
            rdy_idx   = IDX_W'(i);
         end
      end
   end

   assign available = free_found;
   assign do_issue  = issueValid && free_found;
   assign dispatch  = rdy_found && unit_idle;

   // The free-slot choice uses pre-edge busy bits, so a slot dispatched this
   // edge is never re-used on the same edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         busy <= '0;
         p1   <= '0;
         p2   <= '0;
`ifdef MUL_HIGH_EN
         slot_hi <= '0;
`endif
         for (int i = 0; i < ENTRIES; i++) begin
            dest[i]    <= '0;
            slot_q1[i] <= '0;
            slot_q2[i] <= '0;
            slot_v1[i] <= '0;
            slot_v2[i] <= '0;
         end
      end else if (flush) begin
         busy <= '0;
         p1   <= '0;
         p2   <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (busy[i]) begin
               p1[i]      <= snp_r1[i][DATA_W];
               slot_v1[i] <= snp_r1[i][DATA_W-1:0];
               p2[i]      <= snp_r2[i][DATA_W];
               slot_v2[i] <= snp_r2[i][DATA_W-1:0];
            end
         end
         if (dispatch) busy[rdy_idx] <= 1'b0;
         if (do_issue) begin
            busy[free_idx]    <= 1'b1;
            dest[free_idx]    <= robNum;
            slot_q1[free_idx] <= q1;
            slot_q2[free_idx] <= q2;
            p1[free_idx]      <= iss_r1[DATA_W];
            slot_v1[free_idx] <= iss_r1[DATA_W-1:0];
            p2[free_idx]      <= iss_r2[DATA_W];
            slot_v2[free_idx] <= iss_r2[DATA_W-1:0];
`ifdef MUL_HIGH_EN
            slot_hi[free_idx] <= (issueSub == SUB_MULH);
`endif
         end
      end
   end

   mul_unit #(
      .ROB_W   (ROB_W),
      .LATENCY (LATENCY)
   ) u_unit (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .start    (dispatch),
      .op_a     (slot_v1[rdy_idx]),
      .op_b     (slot_v2[rdy_idx]),
`ifdef MUL_HIGH_EN
      .op_hi    (slot_hi[rdy_idx]),
`endif
      .op_rob   (dest[rdy_idx]),
      .cdbGrant (cdbGrant),
      .idle     (unit_idle),
      .cdbValid (cdbValid),
      .cdbRob   (cdbRob),
      .cdbData  (cdbData)
   );

endmodule

// File: tb/tb_mul_rs.sv
module tb_mul_rs;
   import mul_pkg::*;

   localparam int ENTRIES = 2;
   localparam int ROB_W   = 3;
   localparam int LATENCY = 4;
`ifdef MUL_HIGH_EN
   localparam bit HIGH = 1'b1;
`else
   localparam bit HIGH = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              flush;
   logic              issueValid;
   logic [3:0]        issueSub;
   logic [ROB_W-1:0]  robNum;
   logic [31:0]       data1, data2;
   logic              q1Valid, q2Valid;
   logic [ROB_W-1:0]  q1, q2;
   logic              cdb1Valid, cdb2Valid;
   logic [ROB_W-1:0]  cdb1Rob, cdb2Rob;
   logic [31:0]       cdb1Data, cdb2Data;
   logic              available;
   logic              cdbValid;
   logic [ROB_W-1:0]  cdbRob;
   logic [31:0]       cdbData;
   logic              cdbGrant;

   int checks = 0;
   int errors = 0;

   mul_rs #(.ENTRIES(ENTRIES), .ROB_W(ROB_W), .LATENCY(LATENCY)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .issueValid(issueValid), .issueSub(issueSub), .robNum(robNum),
      .data1(data1), .data2(data2), .q1Valid(q1Valid), .q2Valid(q2Valid),
      .q1(q1), .q2(q2),
      .cdb1Valid(cdb1Valid), .cdb1Rob(cdb1Rob), .cdb1Data(cdb1Data),
      .cdb2Valid(cdb2Valid), .cdb2Rob(cdb2Rob), .cdb2Data(cdb2Data),
      .available(available), .cdbValid(cdbValid), .cdbRob(cdbRob),
      .cdbData(cdbData), .cdbGrant(cdbGrant)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  sub;
      logic [2:0]  rob;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[6];

   // Reference: full-precision product, then pick the word the op asks for.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] sub);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      if (HIGH && sub == SUB_MULH) return p[63:32];
      return p[31:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      flush = 0; issueValid = 0; issueSub = 0; robNum = 0;
      data1 = 0; data2 = 0; q1Valid = 0; q2Valid = 0; q1 = 0; q2 = 0;
      cdb1Valid = 0; cdb1Rob = 0; cdb1Data = 0;
      cdb2Valid = 0; cdb2Rob = 0; cdb2Data = 0;
      cdbGrant = 0;
   endtask

   task automatic drive_issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sub,
                              input logic [2:0] rob, input logic p1v, input logic [2:0] t1,
                              input logic p2v, input logic [2:0] t2);
      issueValid = 1; issueSub = sub; robNum = rob; data1 = a; data2 = b;
      q1Valid = p1v; q1 = t1; q2Valid = p2v; q2 = t2;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sub,
                        input logic [2:0] rob, input logic p1v, input logic [2:0] t1,
                        input logic p2v, input logic [2:0] t2);
      drive_issue(a, b, sub, rob, p1v, t1, p2v, t2);
      tick;
      issueValid = 0; q1Valid = 0; q2Valid = 0;
   endtask

   task automatic bcast(input int which, input logic [2:0] rob, input logic [31:0] d);
      if (which == 1) begin cdb1Valid = 1; cdb1Rob = rob; cdb1Data = d; end
      else            begin cdb2Valid = 1; cdb2Rob = rob; cdb2Data = d; end
      tick;
      cdb1Valid = 0; cdb2Valid = 0;
   endtask

   task automatic grant;
      cdbGrant = 1;
      tick;
      cdbGrant = 0;
   endtask

   // Counts edges until cdbValid is seen; an expired budget is a failure.
   task automatic wait_valid(input string name, output int n);
      n = 0;
      while (!cdbValid && n < 200) begin
         tick;
         n++;
      end
      if (!cdbValid) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: cdbValid=0 after %0d cycles, required 1", name, n);
      end
   endtask

   task automatic expect_result(input string name, input logic [2:0] rob, input logic [31:0] d,
                                input int lat);
      int n;
      wait_valid(name, n);
      if (lat >= 0) check({name, " latency"}, 64'(n), 64'(lat));
      check({name, " rob"}, 64'(cdbRob), 64'(rob));
      check({name, " data"}, 64'(cdbData), 64'(d));
   endtask

   initial begin
      int n;
      int seen;
      logic [31:0] qa[$];
      logic [2:0]  qr[$];

      vecs[0] = '{32'd7, 32'd6, SUB_MUL, 3'd3, 32'd42};
      vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, SUB_MUL, 3'd1, 32'h0000_0001};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, SUB_MULH, 3'd2,
                  HIGH ? 32'hFFFF_FFFE : 32'h0000_0001};
      vecs[3] = '{32'h0, 32'h1234, SUB_MUL, 3'd0, 32'h0};
      vecs[4] = '{32'h0001_0000, 32'h0001_0000, SUB_MULH, 3'd5,
                  HIGH ? 32'h1 : 32'h0};
      vecs[5] = '{32'h1234_5678, 32'd9, SUB_MUL, 3'd7, 32'hA3D7_0A38};

      idle_inputs();
      reset = 0;
      tick; tick;
      reset = 1;
      check("reset available", 64'(available), 64'd1);
      check("reset cdbValid", 64'(cdbValid), 64'd0);
      check("reset cdbRob", 64'(cdbRob), 64'd0);
      check("reset cdbData", 64'(cdbData), 64'd0);

      // Ready operands: result at N+1+LATENCY edges after issue
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].rob, 0, 0, 0, 0);
         expect_result($sformatf("vec%0d", i), vecs[i].rob, vecs[i].exp, 1 + LATENCY);
         grant();
         check($sformatf("vec%0d post-grant cdbValid", i), 64'(cdbValid), 64'd0);
         check($sformatf("vec%0d post-grant available", i), 64'(available), 64'd1);
      end

      // Pending operand resolved by cdb2 a few cycles later, with a decoy tag first
      issue(32'd3, 32'hDEAD_BEEF, SUB_MUL, 3'd6, 0, 0, 1, 3'd5);
      bcast(2, 3'd4, 32'h99);
      tick; tick;
      check("pending no early result", 64'(cdbValid), 64'd0);
      bcast(2, 3'd5, 32'h10);
      expect_result("pending cdb2", 3'd6, 32'h30, 1 + LATENCY);
      grant();

      // Same-cycle issue and broadcast
      drive_issue(32'd3, 32'hDEAD_BEEF, SUB_MUL, 3'd6, 0, 0, 1, 3'd5);
      cdb2Valid = 1; cdb2Rob = 3'd5; cdb2Data = 32'h10;
      tick;
      issueValid = 0; q2Valid = 0; cdb2Valid = 0;
      expect_result("same-cycle cdb2", 3'd6, 32'h30, 1 + LATENCY);
      grant();

      // q1 pending, resolved by cdb1; cdb1 beats cdb2 on an equal tag
      issue(32'h0, 32'd7, SUB_MUL, 3'd4, 1, 3'd2, 0, 0);
      cdb1Valid = 1; cdb1Rob = 3'd2; cdb1Data = 32'd9;
      cdb2Valid = 1; cdb2Rob = 3'd2; cdb2Data = 32'd100;
      tick;
      cdb1Valid = 0; cdb2Valid = 0;
      expect_result("cdb1 priority", 3'd4, 32'd63, 1 + LATENCY);
      grant();

      // Backpressure: outputs stable while ungranted; second slot waits
      issue(32'd5, 32'd5, SUB_MUL, 3'd1, 0, 0, 0, 0);
      issue(32'd3, 32'd4, SUB_MUL, 3'd2, 0, 0, 0, 0);
      expect_result("bp first", 3'd1, 32'd25, -1);
      for (int c = 0; c < 5; c++) begin
         tick;
         check($sformatf("bp hold %0d", c), {cdbValid, 28'd0, cdbRob, cdbData},
               {1'b1, 28'd0, 3'd1, 32'd25});
      end
      check("bp available", 64'(available), 64'd1);
      grant();
      check("bp drop", 64'(cdbValid), 64'd0);
      expect_result("bp second", 3'd2, 32'd12, 1 + LATENCY);
      grant();

      // Full: two pending slots, third issue ignored
      issue(32'h0, 32'd10, SUB_MUL, 3'd1, 1, 3'd6, 0, 0);
      issue(32'h0, 32'd5,  SUB_MUL, 3'd2, 1, 3'd7, 0, 0);
      check("full available", 64'(available), 64'd0);
      issue(32'd2, 32'd2, SUB_MUL, 3'd4, 0, 0, 0, 0);
      bcast(1, 3'd6, 32'd2);
      bcast(1, 3'd7, 32'd3);
      expect_result("full first", 3'd1, 32'd20, -1);
      grant();
      expect_result("full second", 3'd2, 32'd15, -1);
      grant();
      seen = 0;
      for (int c = 0; c < 3 * LATENCY; c++) begin
         tick;
         if (cdbValid) seen++;
      end
      check("full third ignored", 64'(seen), 64'd0);

      // Flush mid-BUSY with a same-cycle issue
      issue(32'd9, 32'd9, SUB_MUL, 3'd3, 0, 0, 0, 0);
      tick; tick;
      flush = 1;
      drive_issue(32'd4, 32'd4, SUB_MUL, 3'd5, 0, 0, 0, 0);
      tick;
      flush = 0; issueValid = 0;
      check("flush available", 64'(available), 64'd1);
      seen = 0;
      for (int c = 0; c < 4 * LATENCY; c++) begin
         tick;
         if (cdbValid) seen++;
      end
      check("flush no result", 64'(seen), 64'd0);
      issue(32'd2, 32'd3, SUB_MUL, 3'd0, 0, 0, 0, 0);
      expect_result("after flush", 3'd0, 32'd6, 1 + LATENCY);
      // Flush while a result is waiting for grant
      flush = 1;
      tick;
      flush = 0;
      check("flush in DONE", 64'(cdbValid), 64'd0);

      // Randomized pairs against the reference model, in dispatch (issue) order
      for (int p = 0; p < 20; p++) begin
         for (int k = 0; k < 2; k++) begin
            logic [31:0] a, b;
            logic [3:0]  s;
            logic [2:0]  r;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            s = 4'($urandom_range(0, 1));
            r = 3'($urandom_range(0, 7));
            qa.push_back(ref_mul(a, b, s));
            qr.push_back(r);
            issue(a, b, s, r, 0, 0, 0, 0);
         end
         for (int k = 0; k < 2; k++) begin
            logic [31:0] ea;
            logic [2:0]  er;
            ea = qa.pop_front();
            er = qr.pop_front();
            expect_result($sformatf("rand %0d.%0d", p, k), er, ea, -1);
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++) tick;
            grant();
         end
      end

      // Reset while a result waits: outputs zeroed
      issue(32'd3, 32'd3, SUB_MUL, 3'd7, 0, 0, 0, 0);
      expect_result("pre-reset", 3'd7, 32'd9, 1 + LATENCY);
      reset = 0;
      tick;
      reset = 1;
      check("rst cdbValid", 64'(cdbValid), 64'd0);
      check("rst cdbRob", 64'(cdbRob), 64'd0);
      check("rst cdbData", 64'(cdbData), 64'd0);
      check("rst available", 64'(available), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
